// File: rtl/asap_pkg.sv
// Shared definitions for the ASAP ER configuration sequencer and immutability monitor.
package asap_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_VALIDATE    = 3'd1,
        ST_LOCKED      = 3'd2,
        ST_UNLOCK_WAIT = 3'd3,
        ST_ERROR       = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MIN_STAGE = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_MAX_STAGE = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_CTRL      = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 2'd3;

    localparam int unsigned CTRL_COMMIT  = 0;
    localparam int unsigned CTRL_UNLOCK  = 1;
    localparam int unsigned CTRL_CLR_CNT = 2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ORDER   = 2'd1;
    localparam logic [1:0] ERR_ALIGN   = 2'd2;
    localparam logic [1:0] ERR_OVERLAP = 2'd3;

    // Protected regions also used by the immutability monitor.
    localparam logic [DATA_W-1:0] META_MIN_DEF = 16'h0140;
    localparam logic [DATA_W-1:0] META_MAX_DEF = 16'h016A;
    localparam logic [DATA_W-1:0] IVT_MIN_DEF  = 16'hFFE0;

endpackage

// File: rtl/asap_er_cfg_ctrl_if.sv
// Register port bundle for the ASAP ER configuration sequencer.
interface asap_er_cfg_ctrl_if;
    import asap_pkg::*;

    logic              cfg_wr;
    logic              cfg_rd;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic [DATA_W-1:0] cfg_rdata;
    logic              cfg_wr_rej;

    modport master (output cfg_wr, cfg_rd, cfg_addr, cfg_wdata, input cfg_rdata, cfg_wr_rej);
    modport slave  (input cfg_wr, cfg_rd, cfg_addr, cfg_wdata, output cfg_rdata, cfg_wr_rej);

endinterface

// File: rtl/asap_er_range_check.sv
// Combinational validation of a candidate ER against ordering, alignment and protected regions.
module asap_er_range_check
    import asap_pkg::*;
#(
    parameter logic [15:0] META_MIN = META_MIN_DEF,
    parameter logic [15:0] META_MAX = META_MAX_DEF,
    parameter logic [15:0] IVT_MIN  = IVT_MIN_DEF
) (
    input  logic [15:0] lo,
    input  logic [15:0] hi,
    output logic [1:0]  err_c
);

    // Inclusive intersection tests; the IVT runs to the top of memory.
    always_comb begin
        err_c = ERR_NONE;
        if (lo > hi)
            err_c = ERR_ORDER;
        else if (lo[0] || hi[0])
            err_c = ERR_ALIGN;
        else if ((lo <= META_MAX && hi >= META_MIN) || hi >= IVT_MIN)
            err_c = ERR_OVERLAP;
    end

endmodule

// File: rtl/asap_er_cfg_ctrl.sv
// ASAP ER configuration sequencer: stages, validates, commits and locks the monitor ER bounds.
// Optional abort-event counter enabled by defining ASAP_ABORT_CNT_EN.
module asap_er_cfg_ctrl
    import asap_pkg::*;
#(
    parameter logic [15:0]  META_MIN = META_MIN_DEF,
    parameter logic [15:0]  META_MAX = META_MAX_DEF,
    parameter logic [15:0]  IVT_MIN  = IVT_MIN_DEF,
    parameter int unsigned  CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    asap_er_cfg_ctrl_if.slave bus,
    input  logic [15:0]      pc,
    input  logic             exec,
    output logic [15:0]      er_min,
    output logic [15:0]      er_max,
    output logic             er_locked,
    output logic [1:0]       cfg_err,
    output logic [CNT_W-1:0] abort_cnt
);

    state_t      state;
    logic [15:0] stage_min;
    logic [15:0] stage_max;
    logic [15:0] rdata_q;
    logic        wr_rej_q;
    logic [15:0] rd_mux_c;
    logic [1:0]  chk_err_c;
    logic        wr_stage_c;
    logic        wr_ctrl_c;
    logic        commit_c;
    logic        unlock_c;
    logic        pc_out_c;

    assign wr_stage_c = bus.cfg_wr && (bus.cfg_addr == ADDR_MIN_STAGE || bus.cfg_addr == ADDR_MAX_STAGE);
    assign wr_ctrl_c  = bus.cfg_wr && (bus.cfg_addr == ADDR_CTRL);
    assign commit_c   = wr_ctrl_c && bus.cfg_wdata[CTRL_COMMIT];
    assign unlock_c   = wr_ctrl_c && bus.cfg_wdata[CTRL_UNLOCK];
    assign pc_out_c   = (pc < er_min) || (pc > er_max);

    asap_er_range_check #(
        .META_MIN (META_MIN),
        .META_MAX (META_MAX),
        .IVT_MIN  (IVT_MIN)
    ) u_range_check (
        .lo    (stage_min),
        .hi    (stage_max),
        .err_c (chk_err_c)
    );

    // STATUS reflects register state before any same-cycle write lands.
    always_comb begin
        rd_mux_c = '0;
        case (bus.cfg_addr)
            ADDR_MIN_STAGE: rd_mux_c = stage_min;
            ADDR_MAX_STAGE: rd_mux_c = stage_max;
            ADDR_STATUS:    rd_mux_c = {8'(abort_cnt), 3'(state), cfg_err, er_locked, exec, 1'b0};
            default:        rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            stage_min <= '0;
            stage_max <= '0;
            er_min    <= '0;
            er_max    <= '0;
            er_locked <= 1'b0;
            cfg_err   <= ERR_NONE;
            rdata_q   <= '0;
            wr_rej_q  <= 1'b0;
        end else begin
            wr_rej_q <= 1'b0;
            if (bus.cfg_rd)
                rdata_q <= rd_mux_c;
            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (wr_stage_c) begin
                        if (bus.cfg_addr == ADDR_MIN_STAGE) stage_min <= bus.cfg_wdata;
                        else                                stage_max <= bus.cfg_wdata;
                        state <= ST_IDLE;
                    end else if (commit_c) begin
                        state <= ST_VALIDATE;
                    end
                end
                ST_VALIDATE: begin
                    if (wr_stage_c || commit_c)
                        wr_rej_q <= 1'b1;
                    if (chk_err_c == ERR_NONE) begin
                        state     <= ST_LOCKED;
                        er_min    <= stage_min;
                        er_max    <= stage_max;
                        er_locked <= 1'b1;
                        cfg_err   <= ERR_NONE;
                    end else begin
                        state   <= ST_ERROR;
                        cfg_err <= chk_err_c;
                    end
                end
                ST_LOCKED: begin
                    if (wr_stage_c || commit_c)
                        wr_rej_q <= 1'b1;
                    if (unlock_c)
                        state <= ST_UNLOCK_WAIT;
                end
                ST_UNLOCK_WAIT: begin
                    if (wr_stage_c || commit_c)
                        wr_rej_q <= 1'b1;
                    // Grant is deferred while execution is inside the ER.
                    if (pc_out_c) begin
                        state     <= ST_IDLE;
                        er_locked <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_rdata  = rdata_q;
    assign bus.cfg_wr_rej = wr_rej_q;

`ifdef ASAP_ABORT_CNT_EN
    logic exec_d;
    logic clr_c;
    logic fall_c;

    assign clr_c  = wr_ctrl_c && bus.cfg_wdata[CTRL_CLR_CNT];
    assign fall_c = exec_d && !exec && (state == ST_LOCKED || state == ST_UNLOCK_WAIT);

    // Saturating abort counter; clear takes priority over a coincident fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_d    <= 1'b0;
            abort_cnt <= '0;
        end else begin
            exec_d <= exec;
            if (clr_c)
                abort_cnt <= '0;
            else if (fall_c && abort_cnt != '1)
                abort_cnt <= abort_cnt + CNT_W'(1);
        end
    end
`else
    assign abort_cnt = '0;
`endif

endmodule
